conv3x3_engine: RTL and testbench
=================================

# conv3x3_engine

Parametrised streaming 3x3 convolution engine that replaces the fixed grayscale line-buffer/convolution pair in the image-processing path. It sits after grayscale conversion and feeds the RGB output mux. It internally buffers two rows, builds a 3x3 window, and applies a run-time selected kernel mode. Frame geometry and mode are latched per frame.

## Interface
- PIX_W, 12, pixel width in bits.
- MAX_COLS, 1280, maximum active pixels per row, which is the line-buffer depth.
- COL_W, $clog2(MAX_COLS+1), column counter width (derived, not overridable).

- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-low.
- iSOF  in  1  start of frame; restarts row/column counting and latches iMODE/iCOLS.
- iMODE  in  2  kernel mode: 0 pass, 1 Sobel X, 2 Sobel Y, 3 |Gx|+|Gy|.
- iCOLS  in  COL_W  active row width.
- iDATA  in  PIX_W  input grayscale pixel.
- iDVAL  in  1  iDATA valid.
- oDATA  out  PIX_W  filtered pixel.
- oDVAL  out  1  oDATA valid.
- oEDGE  out  1  output pixel's window is incomplete (border).

## Operation
- Counters: col/row count accepted pixels (iDVAL=1). col wraps from cols_q-1 to 0 and increments row. row saturates at its maximum value.
- iSOF: col and row are cleared, and mode_q/cols_q are latched.
  - If iDVAL is also high in the same cycle, that pixel is (0,0).
  - iCOLS equal to 0 or greater than MAX_COLS latches MAX_COLS.
- iMODE/iCOLS changes between iSOF pulses are ignored.
- Line buffers:
  - Two line buffers are addressed by col, with read-before-write on the same address.
  - Buffer A returns row r-1 and is written with the input pixel.
  - Buffer B returns row r-2 and is written with buffer A's read data.
- Window: a 3x3 register array shifts one column per accepted pixel. The new column is {B, A, input}.
- Each accepted input pixel (r,c) produces exactly one output, centred at (r-1,c-1).
  - When r<2 or c<2: oEDGE=1 and oDATA=0.
  - Otherwise oEDGE=0 and oDATA follows the mode.
- Arithmetic: Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Both are signed and PIX_W+4 bits wide, with no overflow.
  - Mode 0: p11.
  - Modes 1 and 2: |Gx| or |Gy|.
  - Mode 3: |Gx|+|Gy|.
  - Every result saturates to 2^PIX_W-1.
- Line-buffer contents are not cleared at reset or iSOF. The border masking makes stale data invisible.

## Timing
- Pipeline advances only on iDVAL:
  - Pixel accepted at edge T.
  - RAM read at T.
  - Window updated at the next accepted edge slot.
  - Gx/Gy registered at T+2.
  - Result registered at T+3.
- Fixed latency of 3 cycles: oDVAL at edge T+3 equals iDVAL at edge T. The pipeline is free-running; no backpressure.
- Gaps in iDVAL produce identical output data, and the oDVAL count equals the iDVAL count.
- Reset values: oDATA=0, oDVAL=0, oEDGE=0, row/col=0, mode_q=0, cols_q=MAX_COLS, window=0.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously). After release, no oDVAL appears until new pixels are accepted.
- iSOF mid-row: in-flight outputs from the old frame still drain with their original oEDGE/oDATA. The new pixel starts at (0,0).

## Structure
- conv3x3_pkg holds:
  - the mode_t enum (MODE_PASS, MODE_SOBEL_X, MODE_SOBEL_Y, MODE_GRAD);
  - default PIX_W/MAX_COLS constants;
  - the sat_abs function that saturates a signed value to PIX_W bits.
- Sub-module line_buffer (parametrised width and depth, single clock, read-before-write, registered read) is instantiated twice.

## Test plan
- Reset test:
  - Stimulus: drive iRST=0 mid-stream with iDVAL=1.
  - Response: oDVAL/oDATA/oEDGE go to 0 without waiting for a clock edge. After release and iSOF, the first pixel is counted as (0,0).
- Pass-through border test:
  - Stimulus: mode 0, iCOLS=8, pixel=16*row+col over 4 rows.
  - Response: rows 0-1 and columns 0-1 give oEDGE=1 and oDATA=0. Input (2,2) gives oDATA=0x011 exactly 3 cycles later.
- Sobel X step test:
  - Stimulus: mode 1, iCOLS=8, columns 0-3=0 and 4-7=100.
  - Response: centres at columns 3 and 4 output 400. All other interior centres output 0.
- Saturation test:
  - Stimulus: mode 3, checkerboard of 0/4095.
  - Response: every interior output is 4095.
- Gapped-valid test:
  - Stimulus: the same frame with iDVAL randomly low 50% of cycles.
  - Response: the oDATA sequence is identical to the continuous run, and the oDVAL count equals the iDVAL count.
- Latching test:
  - Stimulus: iMODE changed at row 3, and iCOLS=0 at iSOF.
  - Response: the mode is unchanged until the next iSOF, and the column wrap occurs at MAX_COLS-1.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// conv3x3 shared types and helpers.
// Kernel mode enum, default geometry, saturating magnitude.
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_SOBEL_X = 2'd1,
        MODE_SOBEL_Y = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_t;

    localparam int DEF_PIX_W    = 12;
    localparam int DEF_MAX_COLS = 1280;

    // |v| clamped to 2^w-1; caller truncates to w bits.
    function automatic logic [31:0] sat_abs(
        input logic signed [31:0] v,
        input int                 w
    );
        logic [31:0] mag;
        logic [31:0] lim;
        mag = (v < 0) ? -v : v;
        lim = (32'd1 << w) - 32'd1;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/conv3x3_if.sv
// conv3x3 pixel stream bundle.
// Frame control, input pixel and filtered output.
interface conv3x3_if #(
    parameter int PIX_W = 12,
    parameter int COL_W = 11
);
    logic             iSOF;
    logic [1:0]       iMODE;
    logic [COL_W-1:0] iCOLS;
    logic [PIX_W-1:0] iDATA;
    logic             iDVAL;
    logic [PIX_W-1:0] oDATA;
    logic             oDVAL;
    logic             oEDGE;

    modport master (
        output iSOF, iMODE, iCOLS, iDATA, iDVAL,
        input  oDATA, oDVAL, oEDGE
    );

    modport slave (
        input  iSOF, iMODE, iCOLS, iDATA, iDVAL,
        output oDATA, oDVAL, oEDGE
    );
endinterface

// File: rtl/conv3x3_engine_line_buffer.sv
// Single-clock row store, registered read.
// Read returns the old word when read and write hit one address.
module line_buffer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1280,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);
    logic [WIDTH-1:0] mem [DEPTH];

    // RAM port: contents are never cleared, border masking hides them
    always_ff @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
        if (wrEn) mem[wrAddr] <= wrData;
    end
endmodule

// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution: two line buffers, window, kernel.
// Fixed 3-cycle latency from accepted pixel to output.
module conv3x3_engine
    import conv3x3_pkg::*;
#(
    parameter  int PIX_W    = DEF_PIX_W,
    parameter  int MAX_COLS = DEF_MAX_COLS,
    localparam int COL_W    = $clog2(MAX_COLS + 1)
) (
    input logic       iCLK,
    input logic       iRST,
    conv3x3_if.slave  bus
);
    localparam int AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int ACC_W = PIX_W + 4;

    logic [COL_W-1:0] col, row, colsQ;
    logic [COL_W-1:0] curCol, curRow, effCols, latchCols, rowInc;
    mode_t            modeQ, effMode;
    logic             lastCol;

    logic             v1, v2, v3;
    logic             edge1, edge2, edge3;
    mode_t            mode1, mode2, mode3;
    logic [PIX_W-1:0] pix1, rdA, rdB, centreQ;
    logic [AW-1:0]    col1;

    logic [2:0][2:0][PIX_W-1:0] win;
    logic [ACC_W-1:0]        gxR, gxL, gyB, gyT;
    logic signed [ACC_W-1:0] gx, gy, gxQ, gyQ;
    logic [PIX_W-1:0]        satX, satY, satG, result;

    // Coordinates and frame settings seen by the current pixel
    always_comb begin
        curCol    = bus.iSOF ? '0 : col;
        curRow    = bus.iSOF ? '0 : row;
        latchCols = bus.iCOLS;
        if (bus.iCOLS == '0 || bus.iCOLS > COL_W'(MAX_COLS))
            latchCols = COL_W'(MAX_COLS);
        effCols   = bus.iSOF ? latchCols : colsQ;
        effMode   = bus.iSOF ? mode_t'(bus.iMODE) : modeQ;
        lastCol   = (curCol == effCols - 1'b1);
        rowInc    = (&curRow) ? curRow : curRow + 1'b1;
    end

    // Row/column counters and per-frame latches
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col   <= '0;
            row   <= '0;
            modeQ <= MODE_PASS;
            colsQ <= COL_W'(MAX_COLS);
        end else begin
            if (bus.iSOF) begin
                modeQ <= effMode;
                colsQ <= latchCols;
            end
            if (bus.iDVAL) begin
                col <= lastCol ? '0 : curCol + 1'b1;
                row <= lastCol ? rowInc : curRow;
            end else if (bus.iSOF) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    line_buffer #(.WIDTH(PIX_W), .DEPTH(MAX_COLS), .AW(AW)) bufA (
        .clk    (iCLK),
        .wrEn   (bus.iDVAL),
        .wrAddr (curCol[AW-1:0]),
        .wrData (bus.iDATA),
        .rdEn   (bus.iDVAL),
        .rdAddr (curCol[AW-1:0]),
        .rdData (rdA)
    );

    // B is fed one cycle late, once A's old word is out
    line_buffer #(.WIDTH(PIX_W), .DEPTH(MAX_COLS), .AW(AW)) bufB (
        .clk    (iCLK),
        .wrEn   (v1),
        .wrAddr (col1),
        .wrData (rdA),
        .rdEn   (bus.iDVAL),
        .rdAddr (curCol[AW-1:0]),
        .rdData (rdB)
    );

    // Stage 1: hold pixel and its tags alongside the RAM reads
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            v1    <= 1'b0;
            pix1  <= '0;
            edge1 <= 1'b0;
            mode1 <= MODE_PASS;
            col1  <= '0;
        end else begin
            v1 <= bus.iDVAL;
            if (bus.iDVAL) begin
                pix1  <= bus.iDATA;
                edge1 <= (curRow < COL_W'(2)) || (curCol < COL_W'(2));
                mode1 <= effMode;
                col1  <= curCol[AW-1:0];
            end
        end
    end

    // Stage 2: shift the window one column per accepted pixel
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            win   <= '0;
            v2    <= 1'b0;
            edge2 <= 1'b0;
            mode2 <= MODE_PASS;
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= rdB;
                win[1][2] <= rdA;
                win[2][2] <= pix1;
                edge2     <= edge1;
                mode2     <= mode1;
            end
        end
    end

    // Sobel sums, unsigned partials then a signed difference
    always_comb begin
        gxR = ACC_W'(win[0][2]) + (ACC_W'(win[1][2]) << 1)
            + ACC_W'(win[2][2]);
        gxL = ACC_W'(win[0][0]) + (ACC_W'(win[1][0]) << 1)
            + ACC_W'(win[2][0]);
        gyB = ACC_W'(win[2][0]) + (ACC_W'(win[2][1]) << 1)
            + ACC_W'(win[2][2]);
        gyT = ACC_W'(win[0][0]) + (ACC_W'(win[0][1]) << 1)
            + ACC_W'(win[0][2]);
        gx  = signed'(gxR - gxL);
        gy  = signed'(gyB - gyT);
    end

    // Stage 3: register gradients and centre pixel
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            gxQ     <= '0;
            gyQ     <= '0;
            centreQ <= '0;
            v3      <= 1'b0;
            edge3   <= 1'b0;
            mode3   <= MODE_PASS;
        end else begin
            v3 <= v2;
            if (v2) begin
                gxQ     <= gx;
                gyQ     <= gy;
                centreQ <= win[1][1];
                edge3   <= edge2;
                mode3   <= mode2;
            end
        end
    end

    // Kernel select with saturation to full scale
    always_comb begin
        satX   = PIX_W'(sat_abs(32'(gxQ), PIX_W));
        satY   = PIX_W'(sat_abs(32'(gyQ), PIX_W));
        satG   = PIX_W'(sat_abs(signed'(32'(satX) + 32'(satY)), PIX_W));
        result = centreQ;
        unique case (mode3)
            MODE_PASS:    result = centreQ;
            MODE_SOBEL_X: result = satX;
            MODE_SOBEL_Y: result = satY;
            MODE_GRAD:    result = satG;
        endcase
    end

    // Output register; borders are forced to zero
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            bus.oDATA <= '0;
            bus.oDVAL <= 1'b0;
            bus.oEDGE <= 1'b0;
        end else begin
            bus.oDVAL <= v3;
            if (v3) begin
                bus.oEDGE <= edge3;
                bus.oDATA <= edge3 ? '0 : result;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine.
// Frame-level reference model, output queue with cycle stamps.
module tb_conv3x3_engine;
    import conv3x3_pkg::*;

    localparam int PW = 12;
    localparam int MC = 16;
    localparam int CW = $clog2(MC + 1);

    typedef struct {
        logic        isEdge;
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    conv3x3_if #(.PIX_W(PW), .COL_W(CW)) bus ();

    conv3x3_engine #(.PIX_W(PW), .MAX_COLS(MC)) dut (
        .iCLK (clk),
        .iRST (rstN),
        .bus  (bus)
    );

    exp_t        expQ[$];
    exp_t        e;
    logic [11:0] img [0:15][0:15];
    logic [11:0] frm [0:15][0:15];
    int          nCmp = 0;
    int          nBad = 0;
    int          nIn  = 0;
    int          nOut = 0;
    int          cyc  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        nCmp++;
        assert (got === want) else begin
            nBad++;
            $error("FAIL %s got %0h exp %0h at cyc %0d", tag, got, want, cyc);
        end
    endtask

    // Output checker: each oDVAL pops exactly one expectation
    always @(negedge clk) begin
        if (bus.oDVAL === 1'b1) begin
            nOut++;
            chk("unexpected_dval", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("oEDGE", 32'(bus.oEDGE), 32'(e.isEdge));
                chk("oDATA", 32'(bus.oDATA), 32'(e.data));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Reference: window from the stored frame, kernel by formula
    function automatic exp_t model(input int r, input int c, input mode_t m);
        exp_t x;
        int   p [3][3];
        int   gx, gy, v;
        x.cyc = 0;
        if (r < 2 || c < 2) begin
            x.isEdge = 1'b1;
            x.data   = '0;
            return x;
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(img[r-2+i][c-2+j]);
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m)
            MODE_PASS:    v = p[1][1];
            MODE_SOBEL_X: v = gx;
            MODE_SOBEL_Y: v = gy;
            default:      v = gx + gy;
        endcase
        if (v > 4095) v = 4095;
        x.isEdge = 1'b0;
        x.data   = 12'(v);
        return x;
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
        bus.iSOF  = 1'b0;
        bus.iDVAL = 1'b0;
    endtask

    task automatic sendPix(input logic sof, input logic [1:0] mDrv,
                           input int colsDrv, input int r, input int c,
                           input logic [11:0] d, input mode_t fm);
        exp_t x;
        @(posedge clk);
        #1;
        bus.iSOF  = sof;
        bus.iMODE = mDrv;
        bus.iCOLS = CW'(colsDrv);
        bus.iDATA = d;
        bus.iDVAL = 1'b1;
        img[r][c] = d;
        x = model(r, c, fm);
        x.cyc = cyc + 3 + 1;
        expQ.push_back(x);
        nIn++;
    endtask

    task automatic fillFrm(input int kind);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                case (kind)
                    0: frm[r][c] = 12'(16*r + c);
                    1: frm[r][c] = (c < 4) ? 12'd0 : 12'd100;
                    2: frm[r][c] = (((r/2) + (c/2)) % 2 == 1) ? 12'd4095 : 12'd0;
                    default: frm[r][c] = 12'($urandom_range(4095, 0));
                endcase
    endtask

    // Mode and width inputs are scrambled from chgRow on
    task automatic runFrame(input mode_t fm, input int colsDrv, input int cols,
                            input int rows, input int gapPct, input int chgRow,
                            input int maxPix);
        int n;
        logic [1:0] mDrv;
        int cDrv;
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (maxPix >= 0 && n >= maxPix) return;
                for (int k = 0; k < 8; k++) begin
                    if ($urandom_range(99, 0) >= gapPct) break;
                    idle();
                end
                mDrv = fm;
                cDrv = colsDrv;
                if (r >= chgRow) begin
                    mDrv = ~mDrv;
                    cDrv = 5;
                end
                sendPix(r == 0 && c == 0, mDrv, cDrv, r, c, frm[r][c], fm);
                n++;
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && expQ.size() > 0; k++) idle();
        idle();
        idle();
        chk(tag, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int cd, ce, rows;
        mode_t rm;

        rstN      = 1'b0;
        bus.iSOF  = 1'b0;
        bus.iMODE = 2'd0;
        bus.iCOLS = '0;
        bus.iDATA = '0;
        bus.iDVAL = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oDVAL", 32'(bus.oDVAL), 32'd0);
        chk("rst_oDATA", 32'(bus.oDATA), 32'd0);
        chk("rst_oEDGE", 32'(bus.oEDGE), 32'd0);
        rstN = 1'b1;

        fillFrm(0);
        runFrame(MODE_PASS, 8, 8, 4, 0, 99, -1);
        drain("pass_drain");

        fillFrm(1);
        runFrame(MODE_SOBEL_X, 8, 8, 4, 0, 99, -1);
        drain("sobx_drain");

        fillFrm(2);
        runFrame(MODE_GRAD, 8, 8, 5, 0, 99, -1);
        drain("sat_drain");

        fillFrm(3);
        runFrame(MODE_GRAD, 8, 8, 4, 0, 99, -1);
        drain("cont_drain");
        nIn  = 0;
        nOut = 0;
        runFrame(MODE_GRAD, 8, 8, 4, 50, 99, -1);
        drain("gap_drain");
        chk("gap_count", 32'(nOut), 32'(nIn));

        fillFrm(3);
        runFrame(MODE_SOBEL_Y, 0, MC, 5, 0, 3, -1);
        drain("latch_drain");

        for (int it = 0; it < 5; it++) begin
            cd   = $urandom_range(20, 0);
            ce   = (cd == 0 || cd > MC) ? MC : cd;
            rows = $urandom_range(5, 3);
            rm   = mode_t'($urandom_range(3, 0));
            fillFrm(3);
            runFrame(rm, cd, ce, rows, 30, 99, -1);
            drain("rand_drain");
        end

        fillFrm(0);
        runFrame(MODE_PASS, 8, 8, 4, 0, 99, 19);
        fillFrm(3);
        runFrame(MODE_GRAD, 6, 6, 4, 0, 99, -1);
        drain("midsof_drain");

        fillFrm(0);
        runFrame(MODE_PASS, 8, 8, 1, 0, 99, 6);
        @(posedge clk);
        #1;
        chk("pre_rst_dval", 32'(bus.oDVAL), 32'd1);
        #1;
        rstN = 1'b0;
        #1;
        chk("async_oDVAL", 32'(bus.oDVAL), 32'd0);
        chk("async_oDATA", 32'(bus.oDATA), 32'd0);
        chk("async_oEDGE", 32'(bus.oEDGE), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        bus.iDVAL = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (6) idle();
        fillFrm(0);
        runFrame(MODE_PASS, 8, 8, 3, 0, 99, -1);
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
